// File: rtl/spi_frame_sequencer.sv
// SPI master that streams a 16 x 16-bit configuration image as one 256-bit frame,
// framed by idle lead and gap intervals, optionally repeating continuously.
module spi_frame_sequencer #(
  parameter int CLK_DIV      = 1,
  parameter int LEAD_PERIODS = 4,
  parameter int GAP_PERIODS  = 10
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        start,
  input  logic        cont,
  output logic        busy,
  output logic        done,
  output logic        spi_en,
  output logic        spi_clk_out,
  output logic        spi_in
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] LEAD_LAST  = 8'(LEAD_PERIODS - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_PERIODS - 1);
  localparam logic [7:0] BIT_LAST   = 8'd255;

  logic [15:0] image_reg [16];

  state_t      state_reg, state_next;
  logic [7:0]  phase_reg, phase_next;
  logic        sclk_reg, sclk_next;
  // Period count in LEAD/GAP, flat bit index in SHIFT.
  logic [7:0]  cnt_reg, cnt_next;
  logic        period_end;
  logic        done_next;
  logic        wr_accept;

  logic        wr_ack_reg, busy_reg, done_reg, spi_en_reg, spi_clk_reg, spi_in_reg;

  assign wr_accept = wr_en && (state_reg == IDLE);

  always_ff @(posedge sys_clk) begin
    if (!rst && wr_accept) begin
      image_reg[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    sclk_next  = sclk_reg;
    cnt_next   = cnt_reg;
    period_end = 1'b0;
    done_next  = 1'b0;

    if (state_reg != IDLE) begin
      if (phase_reg == PHASE_LAST) begin
        phase_next = 8'd0;
        sclk_next  = ~sclk_reg;
        // A period closes on the falling edge of the internal clock.
        period_end = sclk_reg;
      end else begin
        phase_next = phase_reg + 8'd1;
      end
    end

    case (state_reg)
      IDLE: begin
        phase_next = 8'd0;
        sclk_next  = 1'b0;
        cnt_next   = 8'd0;
        if (start) begin
          state_next = LEAD;
        end
      end
      LEAD: begin
        if (period_end) begin
          if (cnt_reg == LEAD_LAST) begin
            state_next = SHIFT;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      SHIFT: begin
        if (period_end) begin
          if (cnt_reg == BIT_LAST) begin
            state_next = GAP;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      GAP: begin
        if (period_end) begin
          if (cnt_reg == GAP_LAST) begin
            cnt_next = 8'd0;
            if (cont) begin
              state_next = SHIFT;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      phase_reg   <= 8'd0;
      sclk_reg    <= 1'b0;
      cnt_reg     <= 8'd0;
      wr_ack_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      spi_en_reg  <= 1'b1;
      spi_clk_reg <= 1'b0;
      spi_in_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      sclk_reg    <= sclk_next;
      cnt_reg     <= cnt_next;
      wr_ack_reg  <= wr_accept;
      busy_reg    <= (state_next != IDLE);
      done_reg    <= done_next;
      spi_en_reg  <= (state_next != SHIFT);
      spi_clk_reg <= (state_next == SHIFT) && sclk_next;
      // MSB of each word goes first, hence the inverted nibble.
      spi_in_reg  <= (state_next == SHIFT) && image_reg[cnt_next[7:4]][~cnt_next[3:0]];
    end
  end

  assign wr_ack      = wr_ack_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign spi_en      = spi_en_reg;
  assign spi_clk_out = spi_clk_reg;
  assign spi_in      = spi_in_reg;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Randomized self-checking bench for spi_frame_sequencer at H=1 and H=3, checked
// against a bit-level image model and frame timing derived from the frame rules.
module tb_spi_frame_sequencer;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst = 1'b1, cont = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0, wr_en1 = 1'b0, wr_en3 = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [15:0] wr_data = 16'd0;
  logic        ack1, busy1, done1, en1, sclk1, sin1;
  logic        ack3, busy3, done3, en3, sclk3, sin3;

  spi_frame_sequencer #(.CLK_DIV(1), .LEAD_PERIODS(4), .GAP_PERIODS(10)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(ack1), .start(start1), .cont(cont), .busy(busy1), .done(done1),
    .spi_en(en1), .spi_clk_out(sclk1), .spi_in(sin1));

  spi_frame_sequencer #(.CLK_DIV(3), .LEAD_PERIODS(4), .GAP_PERIODS(10)) dut3 (
    .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en3), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(ack3), .start(start3), .cont(cont), .busy(busy3), .done(done3),
    .spi_en(en3), .spi_clk_out(sclk3), .spi_in(sin3));

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] model1 [16];
  logic [15:0] model3 [16];

  int   en_fall_t[$], en_rise_t[$], rise_t[$], done_t[$];
  logic bits_q[$];
  int   busy_rise_t, gate_err;
  logic busy_at_done;

  // {spi_en, spi_clk_out, spi_in, busy, done, wr_ack}
  function automatic logic [5:0] sample(input int sel);
    if (sel == 3) return {en3, sclk3, sin3, busy3, done3, ack3};
    return {en1, sclk1, sin1, busy1, done1, ack1};
  endfunction

  function automatic logic exp_bit(input int sel, input int b);
    logic [15:0] w;
    int bb;
    bb = b % 256;
    w = (sel == 3) ? model3[bb / 16] : model1[bb / 16];
    return w[15 - (bb % 16)];
  endfunction

  function automatic int bit_errors(input int sel);
    int e = 0;
    foreach (bits_q[i]) if (bits_q[i] !== exp_bit(sel, i)) e++;
    return e;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 3) start3 = v; else start1 = v;
  endtask

  task automatic set_wr(input int sel, input logic v);
    if (sel == 3) wr_en3 = v; else wr_en1 = v;
  endtask

  task automatic write_both(input logic [3:0] a, input logic [15:0] d);
    wr_addr = a; wr_data = d; wr_en1 = 1'b1; wr_en3 = 1'b1;
    @(negedge sys_clk);
    wr_en1 = 1'b0; wr_en3 = 1'b0;
    n_checks++;
    if ({ack1, ack3} !== 2'b11) begin
      n_fail++;
      $display("FAIL write_ack addr=%0d got=%b%b exp=11", a, ack1, ack3);
    end
    model1[a] = d;
    model3[a] = d;
  endtask

  // Issues a start and records edge/pulse times until 20 cycles after done.
  task automatic observe(input int sel, input int max_cyc, input int drop_after,
                         input int inject_t, input bit wr_first,
                         input logic [3:0] wa, input logic [15:0] wd);
    logic [5:0] p, c;
    en_fall_t.delete(); en_rise_t.delete(); rise_t.delete(); done_t.delete();
    bits_q.delete();
    busy_rise_t = -1; gate_err = 0; busy_at_done = 1'b1;
    p = sample(sel);
    set_start(sel, 1'b1);
    if (wr_first) begin
      wr_addr = wa; wr_data = wd; set_wr(sel, 1'b1);
      if (sel == 3) model3[wa] = wd; else model1[wa] = wd;
    end
    for (int t = 1; t <= max_cyc; t++) begin
      @(negedge sys_clk);
      c = sample(sel);
      if (t == 1) begin
        set_start(sel, 1'b0); set_wr(sel, 1'b0);
        if (wr_first) begin
          n_checks++;
          if (c[0] !== 1'b1) begin
            n_fail++; $display("FAIL start_write_ack got=%b exp=1", c[0]);
          end
        end
      end
      if (t == inject_t + 1) begin
        set_start(sel, 1'b0); set_wr(sel, 1'b0);
        n_checks++;
        if (c[0] !== 1'b0) begin
          n_fail++; $display("FAIL busy_write_ack got=%b exp=0", c[0]);
        end
      end
      if (t == inject_t) begin
        wr_addr = 4'd0;
        wr_data = ~((sel == 3) ? model3[0] : model1[0]);
        set_wr(sel, 1'b1); set_start(sel, 1'b1);
      end
      if (c[2] && !p[2] && busy_rise_t < 0) busy_rise_t = t;
      if (!c[5] && p[5]) en_fall_t.push_back(t);
      if (c[5] && !p[5]) en_rise_t.push_back(t);
      if (c[4] && !p[4]) begin rise_t.push_back(t); bits_q.push_back(c[3]); end
      if (c[5] && (c[4] || c[3])) gate_err++;
      if (c[1]) begin done_t.push_back(t); busy_at_done = c[2]; end
      if (drop_after >= 0 && en_rise_t.size() == drop_after) cont = 1'b0;
      p = c;
      if (done_t.size() > 0 && t >= done_t[0] + 20) break;
    end
    $display("frame dut=H%0d frames=%0d bits=%0d dones=%0d", sel, en_fall_t.size(),
             bits_q.size(), done_t.size());
  endtask

  task automatic test_reset;
    rst = 1'b1; start1 = 1'b1; start3 = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (sample(1) !== 6'b100000 || sample(3) !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%b/%b exp=100000", i, sample(1), sample(3));
      end
    end
  endtask

  task automatic test_pattern;
    int e;
    for (int a = 0; a < 16; a++)
      write_both(4'(a), (a % 4 == 2) ? 16'h0003 : 16'hFFFF);
    observe(1, 3000, -1, -1, 1'b0, 4'd0, 16'd0);
    n_checks++;
    if (en_fall_t.size() !== 1 || en_rise_t.size() !== 1 || en_rise_t[0] - en_fall_t[0] !== 512) begin
      n_fail++; $display("FAIL pat_frame_len got=%0d exp=512",
        (en_fall_t.size() == 1 && en_rise_t.size() == 1) ? en_rise_t[0] - en_fall_t[0] : -1);
    end
    n_checks++;
    if (en_fall_t.size() !== 1 || en_fall_t[0] - busy_rise_t !== 8) begin
      n_fail++; $display("FAIL pat_lead got=%0d exp=8",
        (en_fall_t.size() == 1) ? en_fall_t[0] - busy_rise_t : -1);
    end
    n_checks++;
    if (rise_t.size() !== 256) begin
      n_fail++; $display("FAIL pat_rises got=%0d exp=256", rise_t.size());
    end
    e = 0;
    for (int i = 0; i < 32 && i < bits_q.size(); i++) if (bits_q[i] !== 1'b1) e++;
    n_checks++;
    if (e !== 0 || bits_q.size() < 48) begin
      n_fail++; $display("FAIL pat_first32 errs=%0d exp=0", e);
    end
    n_checks++;
    if (bits_q.size() < 48 || bits_q[46] !== 1'b1 || bits_q[47] !== 1'b1) begin
      n_fail++; $display("FAIL pat_c_bits got=%b%b exp=11",
        (bits_q.size() >= 48) ? bits_q[46] : 1'bx, (bits_q.size() >= 48) ? bits_q[47] : 1'bx);
    end
    e = bit_errors(1);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL pat_image errs=%0d exp=0", e); end
    n_checks++;
    if (done_t.size() !== 1 || gate_err !== 0) begin
      n_fail++; $display("FAIL pat_done_gate dones=%0d gate_err=%0d exp=1/0", done_t.size(), gate_err);
    end
  endtask

  task automatic test_h3;
    int e, sp;
    for (int a = 0; a < 16; a++) write_both(4'(a), 16'($urandom));
    observe(3, 4000, -1, -1, 1'b0, 4'd0, 16'd0);
    n_checks++;
    if (en_fall_t.size() !== 1 || en_fall_t[0] - busy_rise_t !== 24) begin
      n_fail++; $display("FAIL h3_lead got=%0d exp=24",
        (en_fall_t.size() == 1) ? en_fall_t[0] - busy_rise_t : -1);
    end
    sp = 0;
    for (int i = 1; i < rise_t.size(); i++) if (rise_t[i] - rise_t[i-1] != 6) sp++;
    n_checks++;
    if (sp !== 0 || rise_t.size() !== 256) begin
      n_fail++; $display("FAIL h3_spacing bad=%0d rises=%0d exp=0/256", sp, rise_t.size());
    end
    n_checks++;
    if (done_t.size() !== 1 || en_rise_t.size() !== 1 || done_t[0] - en_rise_t[0] !== 60 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL h3_done dones=%0d dist=%0d busy=%b exp=1/60/0", done_t.size(),
        (done_t.size() > 0 && en_rise_t.size() > 0) ? done_t[0] - en_rise_t[0] : -1, busy_at_done);
    end
    e = bit_errors(3);
    n_checks++;
    if (e !== 0 || gate_err !== 0) begin
      n_fail++; $display("FAIL h3_image errs=%0d gate_err=%0d exp=0/0", e, gate_err);
    end
  endtask

  task automatic test_random;
    int e;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) write_both(4'(a), 16'($urandom));
      observe(1, 3000, -1, -1, 1'b0, 4'd0, 16'd0);
      e = bit_errors(1);
      n_checks++;
      if (e !== 0 || bits_q.size() !== 256) begin
        n_fail++; $display("FAIL rand_image k=%0d errs=%0d bits=%0d exp=0/256", k, e, bits_q.size());
      end
    end
  endtask

  task automatic test_cont;
    int e;
    cont = 1'b1;
    observe(1, 3000, 2, -1, 1'b0, 4'd0, 16'd0);
    cont = 1'b0;
    n_checks++;
    if (en_fall_t.size() !== 2 || en_rise_t.size() !== 2 || en_fall_t[1] - en_rise_t[0] !== 20) begin
      n_fail++; $display("FAIL cont_frames frames=%0d gap=%0d exp=2/20", en_fall_t.size(),
        (en_fall_t.size() == 2 && en_rise_t.size() > 0) ? en_fall_t[1] - en_rise_t[0] : -1);
    end
    e = bit_errors(1);
    n_checks++;
    if (e !== 0 || bits_q.size() !== 512) begin
      n_fail++; $display("FAIL cont_image errs=%0d bits=%0d exp=0/512", e, bits_q.size());
    end
    n_checks++;
    if (done_t.size() !== 1 || en_rise_t.size() !== 2 || done_t[0] - en_rise_t[1] !== 20) begin
      n_fail++; $display("FAIL cont_done dones=%0d exp=1", done_t.size());
    end
  endtask

  task automatic test_busy_write;
    int e;
    observe(1, 3000, -1, 3, 1'b0, 4'd0, 16'd0);
    e = bit_errors(1);
    n_checks++;
    if (e !== 0 || en_fall_t.size() !== 1 || done_t.size() !== 1) begin
      n_fail++; $display("FAIL busy_write errs=%0d frames=%0d dones=%0d exp=0/1/1",
        e, en_fall_t.size(), done_t.size());
    end
  endtask

  task automatic test_start_with_write;
    int e;
    observe(1, 3000, -1, -1, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom));
    e = bit_errors(1);
    n_checks++;
    if (e !== 0 || bits_q.size() !== 256) begin
      n_fail++; $display("FAIL start_write_image errs=%0d bits=%0d exp=0/256", e, bits_q.size());
    end
  endtask

  task automatic test_rst_mid;
    int rises = 0, dones = 0, e;
    logic pclk = 1'b0;
    start1 = 1'b1;
    for (int t = 1; t <= 2000 && rises < 100; t++) begin
      @(negedge sys_clk);
      start1 = 1'b0;
      if (sclk1 && !pclk) rises++;
      pclk = sclk1;
    end
    n_checks++;
    if (rises !== 100) begin n_fail++; $display("FAIL rst_reach got=%0d exp=100", rises); end
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    n_checks++;
    if (sample(1) !== 6'b100000) begin
      n_fail++; $display("FAIL rst_mid_idle got=%b exp=100000", sample(1));
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (done1 || busy1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
    observe(1, 3000, -1, -1, 1'b0, 4'd0, 16'd0);
    e = bit_errors(1);
    n_checks++;
    if (e !== 0 || bits_q.size() !== 256 || done_t.size() !== 1) begin
      n_fail++; $display("FAIL rst_refrm errs=%0d bits=%0d dones=%0d exp=0/256/1",
        e, bits_q.size(), done_t.size());
    end
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_pattern();
    test_h3();
    test_random();
    test_cont();
    test_busy_write();
    test_start_with_write();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
